// File: rtl/ras_pkg.sv
// Shared constants and types for the return-address-stack controller:
// opcodes, link registers and the controller FSM states.
package ras_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [4:0] LINK_X1 = 5'd1;
  localparam logic [4:0] LINK_X5 = 5'd5;

  typedef enum logic {
    IDLE,
    CORET_PUSH
  } ras_state_e;

  function automatic logic is_link(input logic [4:0] r);
    return (r == LINK_X1) || (r == LINK_X5);
  endfunction

endpackage

// File: rtl/ras_decode.sv
// Classifies a 32-bit instruction word as call / return / co-routine swap
// and flags whether it needs a RAS checkpoint.
module ras_decode
  import ras_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic        call_o,
  output logic        ret_o,
  output logic        coret_o,
  output logic        ckpt_o
);

  logic [6:0] opc;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic       rd_link;
  logic       rs1_link;
  logic       is_jal;
  logic       is_jalr;
  logic       is_branch;
  logic       unused_bits;

  assign opc         = instr_i[6:0];
  assign rd          = instr_i[11:7];
  assign rs1         = instr_i[19:15];
  assign unused_bits = ^{instr_i[31:20], instr_i[14:12]};

  assign rd_link   = is_link(rd);
  assign rs1_link  = is_link(rs1);
  assign is_jal    = (opc == OPC_JAL);
  assign is_jalr   = (opc == OPC_JALR);
  assign is_branch = (opc == OPC_BRANCH);

  // Both operands linking with different registers means pop-then-push.
  assign call_o  = (is_jal && rd_link) ||
                   (is_jalr && rd_link && (!rs1_link || (rd == rs1)));
  assign ret_o   = is_jalr && !rd_link && rs1_link;
  assign coret_o = is_jalr && rd_link && rs1_link && (rd != rs1);
  assign ckpt_o  = is_branch || is_jalr;

endmodule

// File: rtl/ras_ctrl.sv
// Return-address-stack controller: turns accepted fetch instructions into
// registered push/pop/checkpoint requests and tracks outstanding checkpoints.
module ras_ctrl #(
  parameter int unsigned PC_BITS    = 32,
  parameter int unsigned CKPT_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  input  logic [31:0]        instr_i,
  input  logic [PC_BITS-1:0] pc_i,
  output logic               ready_o,
  input  logic               flush_i,
  input  logic               resolved_i,
  output logic               ras_push_o,
  output logic               ras_pop_o,
  output logic [PC_BITS-1:0] ras_new_entry_o,
  output logic               ras_is_branch_o,
  output logic               ras_branch_resolved_o,
  output logic               ras_flush_o,
  input  logic               ras_empty_i
);
  import ras_pkg::*;

  localparam int unsigned CNT_W = $clog2(CKPT_DEPTH + 1);

  logic               is_call;
  logic               is_ret;
  logic               is_coret;
  logic               is_ckpt;
  ras_state_e         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [PC_BITS-1:0] coret_ret_q;
  logic [PC_BITS-1:0] link_addr;
  logic               ckpt_full;
  logic               accept;
  logic               branch_d;
  logic               resolve_d;

  ras_decode u_decode (
    .instr_i (instr_i),
    .call_o  (is_call),
    .ret_o   (is_ret),
    .coret_o (is_coret),
    .ckpt_o  (is_ckpt)
  );

  assign link_addr = pc_i + PC_BITS'(4);
  assign ckpt_full = (cnt_q == CNT_W'(CKPT_DEPTH));
  assign ready_o   = (state_q == IDLE) && !flush_i && !(ckpt_full && is_ckpt);
  assign accept    = valid_i && ready_o;

  // Counter moves on the same edge that registers is_branch / resolved.
  assign branch_d  = accept && is_ckpt;
  assign resolve_d = resolved_i && (cnt_q != '0);
  assign cnt_d     = cnt_q + CNT_W'(branch_d) - CNT_W'(resolve_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q               <= IDLE;
      cnt_q                 <= '0;
      coret_ret_q           <= '0;
      ras_push_o            <= 1'b0;
      ras_pop_o             <= 1'b0;
      ras_new_entry_o       <= '0;
      ras_is_branch_o       <= 1'b0;
      ras_branch_resolved_o <= 1'b0;
      ras_flush_o           <= 1'b0;
    end else begin
      ras_push_o            <= 1'b0;
      ras_pop_o             <= 1'b0;
      ras_is_branch_o       <= 1'b0;
      ras_branch_resolved_o <= 1'b0;
      ras_flush_o           <= 1'b0;
      if (flush_i) begin
        ras_flush_o <= 1'b1;
        cnt_q       <= '0;
        state_q     <= IDLE;
      end else begin
        ras_is_branch_o       <= branch_d;
        ras_branch_resolved_o <= resolve_d;
        cnt_q                 <= cnt_d;
        case (state_q)
          IDLE: begin
            if (accept) begin
              if (is_call) begin
                ras_push_o      <= 1'b1;
                ras_new_entry_o <= link_addr;
              end else if (is_ret) begin
                ras_pop_o <= !ras_empty_i;
              end else if (is_coret) begin
                ras_pop_o   <= !ras_empty_i;
                coret_ret_q <= link_addr;
                state_q     <= CORET_PUSH;
              end
            end
          end
          CORET_PUSH: begin
            ras_push_o      <= 1'b1;
            ras_new_entry_o <= coret_ret_q;
            state_q         <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ras_ctrl.sv
// Scoreboard bench for ras_ctrl: directed scenarios plus random traffic,
// expectations from a transaction-level model of the controller.
module tb_ras_ctrl;

  localparam int unsigned PC_BITS = 32;
  localparam int unsigned DEPTH   = 4;
  localparam int K_NONE  = 0;
  localparam int K_CALL  = 1;
  localparam int K_RET   = 2;
  localparam int K_CORET = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               valid_i = 1'b0;
  logic [31:0]        instr_i = '0;
  logic [PC_BITS-1:0] pc_i = '0;
  logic               flush_i = 1'b0;
  logic               resolved_i = 1'b0;
  logic               ras_empty_i = 1'b0;
  logic               ready_o;
  logic               ras_push_o;
  logic               ras_pop_o;
  logic [PC_BITS-1:0] ras_new_entry_o;
  logic               ras_is_branch_o;
  logic               ras_branch_resolved_o;
  logic               ras_flush_o;

  always #5 clk = ~clk;

  ras_ctrl #(.PC_BITS(PC_BITS), .CKPT_DEPTH(DEPTH)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .valid_i               (valid_i),
    .instr_i               (instr_i),
    .pc_i                  (pc_i),
    .ready_o               (ready_o),
    .flush_i               (flush_i),
    .resolved_i            (resolved_i),
    .ras_push_o            (ras_push_o),
    .ras_pop_o             (ras_pop_o),
    .ras_new_entry_o       (ras_new_entry_o),
    .ras_is_branch_o       (ras_is_branch_o),
    .ras_branch_resolved_o (ras_branch_resolved_o),
    .ras_flush_o           (ras_flush_o),
    .ras_empty_i           (ras_empty_i)
  );

  typedef struct {
    bit          push;
    bit          pop;
    bit          br;
    bit          res;
    bit          fl;
    logic [31:0] entry;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  int          outstanding = 0;
  bit          coret_pending = 0;
  logic [31:0] coret_addr = '0;
  bit          dut_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1);
    return {12'h000, rs1, 3'b000, rd, op};
  endfunction

  function automatic int classify(input logic [31:0] ins);
    logic [6:0] op  = ins[6:0];
    logic [4:0] rd  = ins[11:7];
    logic [4:0] rs1 = ins[19:15];
    bit rdl = (rd == 5'd1) || (rd == 5'd5);
    bit rsl = (rs1 == 5'd1) || (rs1 == 5'd5);
    if (op == 7'b1101111) return rdl ? K_CALL : K_NONE;
    if (op == 7'b1100111) begin
      if (rdl && !rsl) return K_CALL;
      if (!rdl && rsl) return K_RET;
      if (rdl && rsl) return (rd == rs1) ? K_CALL : K_CORET;
    end
    return K_NONE;
  endfunction

  // One clock of stimulus: drive at negedge, check ready, predict next outputs.
  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                      input bit fl, input bit res, input bit emp, input bit r);
    exp_t e;
    int   kind;
    bit   ckpt, m_ready, acc, rsv;
    @(negedge clk);
    rst = r; valid_i = v; instr_i = ins; pc_i = pc;
    flush_i = fl; resolved_i = res; ras_empty_i = emp;
    #1;
    e.push = 0; e.pop = 0; e.br = 0; e.res = 0; e.fl = 0; e.entry = '0;
    kind = classify(ins);
    ckpt = (ins[6:0] == 7'b1100011) || (ins[6:0] == 7'b1100111);
    if (r) begin
      outstanding   = 0;
      coret_pending = 0;
      m_ready       = !fl;
    end else begin
      m_ready = !coret_pending && !fl && !(outstanding == DEPTH && ckpt);
    end
    check("ready_o", 32'(ready_o), 32'(m_ready));
    dut_acc = v && ready_o && !r;
    acc = v && m_ready && !r;
    if (!r) begin
      if (fl) begin
        e.fl = 1;
        outstanding   = 0;
        coret_pending = 0;
      end else begin
        rsv   = res && (outstanding > 0);
        e.res = rsv;
        if (coret_pending) begin
          e.push = 1;
          e.entry = coret_addr;
          coret_pending = 0;
        end else if (acc) begin
          e.br = ckpt;
          if (kind == K_CALL) begin
            e.push = 1;
            e.entry = pc + 32'd4;
          end else if (kind == K_RET) begin
            e.pop = !emp;
          end else if (kind == K_CORET) begin
            e.pop = !emp;
            coret_pending = 1;
            coret_addr = pc + 32'd4;
          end
        end
        outstanding = outstanding + ((acc && ckpt) ? 1 : 0) - (rsv ? 1 : 0);
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(0, 32'h0000_0013, 32'h0, 0, 0, 0, 0);
  endtask

  function automatic logic [4:0] rand_reg();
    case ($urandom_range(0, 4))
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd5;
      3: return 5'd2;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] op;
    case ($urandom_range(0, 4))
      0: op = 7'b1101111;
      1: op = 7'b1100111;
      2: op = 7'b1100011;
      3: op = 7'b0010011;
      default: op = 7'($urandom());
    endcase
    return {12'($urandom()), rand_reg(), 3'($urandom()), rand_reg(), op};
  endfunction

  // Monitor: every cycle the DUT presents must match the oldest prediction.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("ras_push_o", 32'(ras_push_o), 32'(mon_e.push));
        check("ras_pop_o", 32'(ras_pop_o), 32'(mon_e.pop));
        check("ras_is_branch_o", 32'(ras_is_branch_o), 32'(mon_e.br));
        check("ras_branch_resolved_o", 32'(ras_branch_resolved_o), 32'(mon_e.res));
        check("ras_flush_o", 32'(ras_flush_o), 32'(mon_e.fl));
        if (mon_e.push) check("ras_new_entry_o", ras_new_entry_o, mon_e.entry);
      end
    end
  end

  initial begin
    logic [31:0] jal_x1, jalr_ret, jalr_coret, beq;
    int fill_acc, total_acc;
    bit r, fl, v;
    logic [31:0] pc;
    jal_x1     = mk(7'b1101111, 5'd1, 5'd0);
    jalr_ret   = mk(7'b1100111, 5'd0, 5'd1);
    jalr_coret = mk(7'b1100111, 5'd5, 5'd1);
    beq        = mk(7'b1100011, 5'd0, 5'd0);

    step(0, 32'h0, 32'h0, 0, 0, 0, 1);
    step(1, beq, 32'h0, 0, 0, 0, 1);
    idle();

    // Call, return with and without stack content, co-routine swap.
    step(1, jal_x1, 32'h100, 0, 0, 0, 0);
    step(1, jal_x1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    step(1, jalr_ret, 32'h300, 0, 0, 0, 0);
    step(1, jalr_ret, 32'h304, 0, 0, 1, 0);
    step(1, jalr_coret, 32'h200, 0, 0, 0, 0);
    step(1, jal_x1, 32'h208, 0, 0, 0, 0);
    step(1, jal_x1, 32'h208, 0, 0, 0, 0);
    step(0, 32'h0, 32'h0, 1, 0, 0, 0);

    // Checkpoint fill: four accepted, fifth waits for a resolve.
    fill_acc = 0;
    total_acc = 0;
    for (int i = 0; i < 14 && total_acc < 5; i++) begin
      step(1, beq, 32'h400 + 32'(i * 4), 0, (i == 8), 0, 0);
      if (dut_acc) begin
        total_acc++;
        if (i < 8) fill_acc++;
      end
    end
    check("beq_fill_accepts", 32'(fill_acc), 32'd4);
    check("beq_total_accepts", 32'(total_acc), 32'd5);

    // Flush while the co-routine push is pending with three checkpoints.
    step(0, 32'h0, 32'h0, 1, 0, 0, 0);
    step(1, beq, 32'h500, 0, 0, 0, 0);
    step(1, beq, 32'h504, 0, 0, 0, 0);
    step(1, jalr_coret, 32'h508, 0, 0, 0, 0);
    step(1, beq, 32'h50C, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, beq, 32'h600 + 32'(i * 4), 0, 0, 0, 0);

    // Reset in the middle of a co-routine swap.
    step(0, 32'h0, 32'h0, 1, 0, 0, 0);
    step(1, jalr_coret, 32'h700, 0, 0, 0, 0);
    step(0, 32'h0, 32'h0, 0, 0, 0, 1);
    idle();
    idle();

    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      fl = ($urandom_range(0, 19) == 0);
      v  = ($urandom_range(0, 3) != 0);
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      step(v, rand_instr(), pc, fl, ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), r);
    end

    idle();
    idle();
    @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ras_ctrl.md
RAS_CTRL -- requirements
Module: ras_ctrl

Interface
REQ-001 Parameter PC_BITS, 32, program-counter width.
REQ-002 Parameter CKPT_DEPTH, 4, maximum unresolved checkpointed branches (equals RAS checkpoint FIFO depth).
REQ-003 Port clk  input  1  single clock; all state on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port valid_i  input  1  fetch offers one instruction.
REQ-006 Port instr_i  input  32  fetched instruction word (32-bit encodings only).
REQ-007 Port pc_i  input  PC_BITS  PC of instr_i.
REQ-008 Port ready_o  output  1  instruction accepted this cycle when valid_i&ready_o.
REQ-009 Port flush_i  input  1  pipeline misprediction flush.
REQ-010 Port resolved_i  input  1  oldest outstanding branch resolved.
REQ-011 Port ras_push_o  output  1  push request to RAS.
REQ-012 Port ras_pop_o  output  1  pop request to RAS.
REQ-013 Port ras_new_entry_o  output  PC_BITS  return address to push.
REQ-014 Port ras_is_branch_o  output  1  take checkpoint in RAS.
REQ-015 Port ras_branch_resolved_o  output  1  release oldest RAS checkpoint.
REQ-016 Port ras_flush_o  output  1  restore RAS checkpoint.
REQ-017 Port ras_empty_i  input  1  RAS currently empty.

Function
REQ-018 Decode: link register = x1 or x5; JAL (1101111) with link rd = CALL; JALR (1100111): rd link and rs1 not link = CALL; rd not link and rs1 link = RET; both link with rd==rs1 = CALL; both link with rd!=rs1 = CORET; BRANCH (1100011) or any JALR = checkpointed branch.
REQ-019 All ras_* outputs SHALL be registered, asserted exactly one cycle after acceptance.
REQ-020 CALL SHALL assert ras_push_o with ras_new_entry_o = pc_i+4 (modulo 2^PC_BITS).
REQ-021 RET SHALL assert ras_pop_o only if ras_empty_i is low in the accept cycle; otherwise no pop.
REQ-022 FSM states IDLE, CORET_PUSH; CORET accepted in IDLE issues pop (subject to REQ-021) next cycle and moves to CORET_PUSH; CORET_PUSH issues the push of pc+4, holds ready_o low, returns to IDLE.
REQ-023 ras_push_o and ras_pop_o SHALL never be asserted in the same cycle.
REQ-024 Checkpointed branch SHALL assert ras_is_branch_o one cycle after acceptance, together with any push/pop of the same instruction; CORET asserts it only with the pop.
REQ-025 Outstanding counter (0..CKPT_DEPTH): +1 on ras_is_branch_o, -1 on ras_branch_resolved_o, unchanged when both.
REQ-026 ras_branch_resolved_o = registered (resolved_i & counter!=0); resolved_i with counter 0 is ignored.
REQ-027 ready_o low when state is CORET_PUSH, flush_i high, or counter==CKPT_DEPTH and instr_i is a checkpointed branch; otherwise high.
REQ-028 flush_i: ras_flush_o asserted next cycle; same edge clears counter, FSM to IDLE, drops any pending push/pop/is_branch; flush has priority over all other inputs.
REQ-029 Non-control or invalid instructions produce no ras_* activity.

Reset
REQ-030 While rst high: FSM IDLE, counter 0, all ras_* outputs 0; ready_o follows REQ-027 from reset state (high).
REQ-031 Reset asserted mid-CORET SHALL discard the pending push.

Structure
REQ-032 Package ras_pkg holds opcode constants (OPC_JAL, OPC_JALR, OPC_BRANCH), link-register indices, and the FSM state enum.
REQ-033 One combinational sub-module ras_decode (instr_i -> CALL/RET/CORET/branch class); counter and FSM stay in ras_ctrl.

Verification
REQ-034 JAL x1 at pc 0x100 -> next cycle ras_push_o=1, ras_new_entry_o=0x104, ras_is_branch_o=0.
REQ-035 JALR x0,0(x1) with ras_empty_i=0 -> ras_pop_o=1, ras_is_branch_o=1; same with ras_empty_i=1 -> ras_pop_o=0, ras_is_branch_o=1.
REQ-036 JALR x5,0(x1) at pc 0x200 -> cycle+1 pop, cycle+2 push 0x204, ready_o low in cycle+1 only.
REQ-037 Five BEQ back-to-back without resolved_i -> four accepted, ready_o low on fifth until resolved_i pulses, then accepted.
REQ-038 flush_i during CORET_PUSH with counter 3 -> ras_flush_o=1 next cycle, no push, counter 0, ready_o high.
